// File: rtl/scope_bank_scan.sv
// scope_bank_scan: a bank of NCH generate-scoped channels. Each channel
// keeps a localparam P and a register w. A nested blk scope redeclares P
// and w (shadowing the outer names) and adds a function F. A scan FSM
// streams four items per channel over a valid/ready port.
module scope_bank_scan #(
  parameter int NCH  = 4,
  parameter int W    = 4,
  parameter int BASE = 1,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [1:0]    out_sel,
  output logic [W-1:0]  out_data,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // The item tables are sized to the full channel-index space so that any
  // index value is in range. Slots at or above NCH read as zero and are
  // never selected by the scan.
  localparam int NSLOT = 1 << CW;

  logic [W-1:0] p_arr  [NSLOT];
  logic [W-1:0] w_arr  [NSLOT];
  logic [W-1:0] bw_arr [NSLOT];
  logic [W-1:0] f_arr  [NSLOT];

  for (genvar k = 0; k < NCH; k++) begin : ch
    localparam logic [W-1:0] P = W'(BASE + k);
    // Alias of the outer P, still reachable once blk shadows the name.
    localparam logic [W-1:0] OUTER_P = P;

    logic [W-1:0] w;

    // Outer data register: reset to P, overwritten by a write to this channel.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        w <= P;
      end else if (wr_en && (wr_ch == CW'(k))) begin
        w <= wr_data;
      end else begin
        w <= w;
      end
    end

    assign p_arr[k] = P;
    assign w_arr[k] = w;

    if (1'b1) begin : blk
      localparam logic [W-1:0] P = W'(32'd2 * OUTER_P);

      logic [W-1:0] w;

      function automatic logic [W-1:0] F(input logic [W-1:0] x);
        return x + P;
      endfunction

      // Shadow register: captures the outer w value being replaced on a write.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          w <= {W{1'b0}};
        end else if (wr_en && (wr_ch == CW'(k))) begin
          w <= w_arr[k];
        end else begin
          w <= w;
        end
      end

      assign bw_arr[k] = w;
      assign f_arr[k]  = F(w);
    end
  end

  for (genvar j = NCH; j < NSLOT; j++) begin : pad
    assign p_arr[j]  = {W{1'b0}};
    assign w_arr[j]  = {W{1'b0}};
    assign bw_arr[j] = {W{1'b0}};
    assign f_arr[j]  = {W{1'b0}};
  end

  state_t        state_r;
  state_t        state_n;
  logic [CW-1:0] ch_r;
  logic [CW-1:0] ch_n;
  logic [1:0]    sel_r;
  logic [1:0]    sel_n;
  logic [W-1:0]  data_r;
  logic [W-1:0]  data_n;
  logic [W-1:0]  item_v;
  logic          load_s;
  logic          last_s;
  logic          busy_r;
  logic          valid_r;
  logic          done_r;

  assign last_s = (ch_r == CW'(NCH - 1)) && (sel_r == 2'd3);

  // Next-state, next-beat selection and item mux; the mux reads pre-edge registers.
  always_comb begin
    state_n = state_r;
    ch_n    = ch_r;
    sel_n   = sel_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = EMIT;
          ch_n    = {CW{1'b0}};
          sel_n   = 2'd0;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_s) begin
            state_n = DONE;
          end else begin
            load_s = 1'b1;
            sel_n  = sel_r + 2'd1;
            if (sel_r == 2'd3) begin
              ch_n = ch_r + CW'(1);
            end else begin
              ch_n = ch_r;
            end
          end
        end else begin
          state_n = EMIT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (sel_n)
      2'd0:    item_v = p_arr[ch_n];
      2'd1:    item_v = w_arr[ch_n];
      2'd2:    item_v = bw_arr[ch_n];
      2'd3:    item_v = f_arr[ch_n];
      default: item_v = {W{1'b0}};
    endcase

    if (load_s) begin
      data_n = item_v;
    end else begin
      data_n = data_r;
    end
  end

  // State, beat fields and status flags, all registered from next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ch_r    <= {CW{1'b0}};
      sel_r   <= 2'd0;
      data_r  <= {W{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      ch_r    <= ch_n;
      sel_r   <= sel_n;
      data_r  <= data_n;
      busy_r  <= (state_n != IDLE);
      valid_r <= (state_n == EMIT);
      done_r  <= (state_n == DONE);
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign out_ch    = ch_r;
  assign out_sel   = sel_r;
  assign out_data  = data_r;
  assign done      = done_r;

endmodule

// File: doc/scope_bank_scan.md
# scope_bank_scan

Parametrised bank of NCH generate-scoped channels, each holding a localparam, a data register, a nested `blk` scope with its own same-named localparam, shadow register and function, plus a scan FSM that streams every scoped value out over a valid/ready port. It generalises the single fixed named-block hierarchy of the scope-resolution tests to N indexed channels with live, writable state. It is the sequential DUT for hierarchical-name and scope-shadowing conversion checks. The bench reads both the streamed port and `ch[k].P`, `ch[k].blk.w` and similar names directly.

## Interface
- NCH, default 4: channel count, ≥1; generate blocks named `ch[0..NCH-1]`.
- W, default 4: data width, ≥2.
- BASE, default 1: seed for per-channel localparams.
- CW, default 2: channel index width, 2^CW ≥ NCH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_ch  in  CW  write target channel.
- wr_data  in  W  write data.
- start  in  1  scan request.
- busy  out  1  FSM not in IDLE.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_ch  out  CW  channel of beat.
- out_sel  out  2  item of beat.
- out_data  out  W  beat value.
- done  out  1  one-cycle scan-complete pulse.

## Operation
- Channel k:
  - `P = (BASE + k) mod 2^W`.
  - `reg w`, reset value P.
- Nested `blk` scope:
  - `P = (2 * outer P) mod 2^W`; this shadows the outer P.
  - `reg w`, reset value 0.
  - `function F(x) = (x + blk.P) mod 2^W`.
- Write: when wr_en=1 and wr_ch<NCH:
  - `ch[wr_ch].w <= wr_data`.
  - `ch[wr_ch].blk.w <=` the old outer w.
  - wr_ch ≥ NCH: the write is ignored with no side effect.
  - Writes are legal in every FSM state.
- Items per channel, by out_sel:
  - 0 = outer P
  - 1 = outer w
  - 2 = blk.w
  - 3 = blk.F(blk.w)
- FSM states and transitions:
  - IDLE: start=1 → EMIT, loading beat (ch 0, sel 0).
  - EMIT, valid&ready, not last beat → load next beat. sel increments; after sel 3, sel wraps to 0 and ch increments.
  - EMIT, valid&ready on beat (NCH-1, 3) → DONE.
  - EMIT, ready=0 → hold.
  - DONE → IDLE unconditionally.
- start is ignored outside IDLE.
- Beat capture: out_ch, out_sel and out_data are registered at the edge that loads the beat, from pre-edge register values.
  - A same-edge write is not reflected in that beat.
  - A write to a channel whose beat is stalled does not change the held out_data.
- Arithmetic is unsigned, truncated to W bits. Wrap-around is required, not an error.

## Timing
- Reset (rst_n=0 at an edge), any state:
  - Next cycle: IDLE, busy=0, out_valid=0, out_ch=0, out_sel=0, out_data=0, done=0, all outer w=P_k, all blk.w=0.
  - A scan in progress is abandoned; no done pulse.
- Start accepted at edge t:
  - out_valid=1 from cycle t+1.
  - First beat is (0, 0, P_0).
- With out_ready held at 1:
  - One beat accepted per cycle; 4·NCH beats.
  - Last accept at edge t+4·NCH.
  - done=1 and busy=1 during cycle t+4·NCH+1.
  - IDLE from t+4·NCH+2; a new start is accepted at that edge or later.
- Stall: out_valid stays 1 and all beat fields stay stable while out_ready=0.
- out_valid=0 in IDLE and DONE.
- Throughput is one beat/cycle. There are no bubbles inside a scan.

## Test plan
- Reset then scan, NCH=4, W=4, BASE=1, ready=1 → 16 consecutive beats:
  - ch0: 1,1,0,2
  - ch1: 2,2,0,4
  - ch2: 3,3,0,6
  - ch3: 4,4,0,8
  - done is a single pulse one cycle after the last beat.
- Write ch2=9, then scan → ch2 beats 3,9,3,9. Direct reads `ch[2].w`=9 and `ch[2].blk.P`=6.
- Wrap, BASE=15 → ch1 P=0, ch0 blk.P=14, ch0 sel3=14, ch3 P=2, ch3 blk.P=4.
- Hold ready=0 for 5 cycles on beat (1,2); write ch1=5 during the stall → out_data stays 0 until accept. Rescan shows ch1 sel1=5, sel2=2.
- Assert start mid-scan, and write wr_ch=4 with CW=3 and NCH=4 → no restart and no register change. Beat count stays 16.
- rst_n=0 at beat 7 → next cycle out_valid=0, busy=0, and all w restored. A fresh scan then matches scenario 1.
